// File: rtl/alu_simd_pkg.sv
// Shared opcode, lane-mode and inversion encodings for the SIMD ALU pipeline.
package alu_simd_pkg;

   localparam logic [3:0] ALU_ADD     = 4'b0000;
   localparam logic [3:0] ALU_NZ_ADD  = 4'b0001;
   localparam logic [3:0] ALU_N_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0011;
   localparam logic [3:0] ALU_XOR_A   = 4'b0100;
   localparam logic [3:0] ALU_XNOR_A  = 4'b0101;
   localparam logic [3:0] ALU_XNOR_B  = 4'b0110;
   localparam logic [3:0] ALU_XOR_B   = 4'b0111;
   localparam logic [3:0] ALU_AND     = 4'b1100;
   localparam logic [3:0] ALU_ANDN    = 4'b1101;
   localparam logic [3:0] ALU_NAND    = 4'b1110;
   localparam logic [3:0] ALU_NX_OR   = 4'b1111;

   localparam logic [1:0] OPM_INV = 2'b10;

   typedef enum logic [1:0] {
      SIMD_ONE  = 2'b00,
      SIMD_TWO  = 2'b01,
      SIMD_FOUR = 2'b10
   } simd_e;

   function automatic simd_e simd_decode(input logic [1:0] s);
      simd_e m;
      case (s)
         2'b01:   m = SIMD_TWO;
         2'b10:   m = SIMD_FOUR;
         default: m = SIMD_ONE;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_simd_lane.sv
// One quarter-width arithmetic lane; carry_o is the 2-bit overflow above LW
// so lanes can be chained exactly into wider three-operand adds.
module alu_simd_lane #(
   parameter int LW = 12
) (
   input  logic [LW-1:0] x_i,
   input  logic [LW-1:0] y_i,
   input  logic [LW-1:0] z_i,
   input  logic [1:0]    cin_i,
   input  logic [1:0]    op_i,
   output logic [LW-1:0] res_o,
   output logic [1:0]    carry_o
);

   logic [LW-1:0] zz;
   logic [LW+1:0] sum;

   // op_i[0] negates z before the add, op_i[1] inverts the sum after it
   assign zz      = op_i[0] ? ~z_i : z_i;
   assign sum     = {2'b00, zz} + {2'b00, x_i} + {2'b00, y_i}
                  + {{LW{1'b0}}, cin_i};
   assign res_o   = op_i[1] ? ~sum[LW-1:0] : sum[LW-1:0];
   assign carry_o = sum[LW+1:LW];

endmodule

// File: rtl/alu_simd_pipe.sv
// Two-stage SIMD ALU: S1 captures operands and modes, S2 computes into P
// with accumulate feedback, lane carry-outs and pattern detect.
module alu_simd_pipe
   import alu_simd_pkg::*;
#(
   parameter int               WIDTH   = 48,
   parameter logic [WIDTH-1:0] PATTERN = '0,
   parameter logic [WIDTH-1:0] MASK    = '1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic             CLR_P,
   input  logic             IN_VALID,
   input  logic [3:0]       ALU_CTRL,
   input  logic [1:0]       OP_MODE,
   input  logic [1:0]       USE_SIMD,
   input  logic             ZSEL,
   input  logic             CIN,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] Z,
   output logic [WIDTH-1:0] P,
   output logic [3:0]       COUT,
   output logic             PATTERN_DETECT,
   output logic             OUT_VALID
);

   localparam int QW = WIDTH / 4;

   logic [WIDTH-1:0] s1_x_q, s1_y_q, s1_z_q;
   logic [3:0]       s1_ctrl_q;
   logic [1:0]       s1_opm_q, s1_simd_q;
   logic             s1_cin_q, s1_zsel_q, s1_valid_q;

   logic [WIDTH-1:0] p_q, p_d;
   logic [3:0]       cout_q, cout_d;
   logic             pd_q, pd_d;
   logic             ov_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_z_q     <= '0;
         s1_ctrl_q  <= '0;
         s1_opm_q   <= '0;
         s1_simd_q  <= '0;
         s1_cin_q   <= 1'b0;
         s1_zsel_q  <= 1'b0;
         s1_valid_q <= 1'b0;
      end else if (CE) begin
         s1_x_q     <= X;
         s1_y_q     <= Y;
         s1_z_q     <= Z;
         s1_ctrl_q  <= ALU_CTRL;
         s1_opm_q   <= OP_MODE;
         s1_simd_q  <= USE_SIMD;
         s1_cin_q   <= CIN;
         s1_zsel_q  <= ZSEL;
         s1_valid_q <= IN_VALID;
      end
   end

   simd_e            mode;
   logic [WIDTH-1:0] z_eff;
   logic             inv;

   assign mode  = simd_decode(s1_simd_q);
   assign z_eff = s1_zsel_q ? p_q : s1_z_q;
   assign inv   = (s1_opm_q == OPM_INV);

   logic [1:0]    cin0, cin1, cin2, cin3;
   logic [1:0]    k0, k1, k2, k3;
   logic [QW-1:0] r0, r1, r2, r3;

   // carries cross a quarter boundary only inside a wider active lane
   assign cin0 = {1'b0, s1_cin_q};
   assign cin1 = (mode == SIMD_FOUR) ? 2'b00 : k0;
   assign cin2 = (mode == SIMD_ONE)  ? k1    : 2'b00;
   assign cin3 = (mode == SIMD_FOUR) ? 2'b00 : k2;

   alu_simd_lane #(.LW(QW)) u_lane0 (
      .x_i(s1_x_q[0*QW +: QW]), .y_i(s1_y_q[0*QW +: QW]),
      .z_i(z_eff[0*QW +: QW]), .cin_i(cin0), .op_i(s1_ctrl_q[1:0]),
      .res_o(r0), .carry_o(k0)
   );
   alu_simd_lane #(.LW(QW)) u_lane1 (
      .x_i(s1_x_q[1*QW +: QW]), .y_i(s1_y_q[1*QW +: QW]),
      .z_i(z_eff[1*QW +: QW]), .cin_i(cin1), .op_i(s1_ctrl_q[1:0]),
      .res_o(r1), .carry_o(k1)
   );
   alu_simd_lane #(.LW(QW)) u_lane2 (
      .x_i(s1_x_q[2*QW +: QW]), .y_i(s1_y_q[2*QW +: QW]),
      .z_i(z_eff[2*QW +: QW]), .cin_i(cin2), .op_i(s1_ctrl_q[1:0]),
      .res_o(r2), .carry_o(k2)
   );
   alu_simd_lane #(.LW(QW)) u_lane3 (
      .x_i(s1_x_q[3*QW +: QW]), .y_i(s1_y_q[3*QW +: QW]),
      .z_i(z_eff[3*QW +: QW]), .cin_i(cin3), .op_i(s1_ctrl_q[1:0]),
      .res_o(r3), .carry_o(k3)
   );

   logic unused_top_carry;
   assign unused_top_carry = k3[1];

   logic [WIDTH-1:0] arith;
   logic [3:0]       arith_cout;

   assign arith = {r3, r2, r1, r0};

   always_comb begin
      arith_cout = {k3[0], 3'b000};
      case (mode)
         SIMD_FOUR: arith_cout = {k3[0], k2[0], k1[0], k0[0]};
         SIMD_TWO:  arith_cout = {k3[0], 1'b0, k1[0], 1'b0};
         default:   arith_cout = {k3[0], 3'b000};
      endcase
   end

   always_comb begin
      p_d    = '0;
      cout_d = '0;
      case (s1_ctrl_q)
         ALU_ADD, ALU_NZ_ADD, ALU_N_ADD, ALU_SUB: begin
            p_d    = arith;
            cout_d = arith_cout;
         end
         ALU_XOR_A, ALU_XOR_B:
            p_d = inv ? ~(s1_x_q ^ z_eff) : (s1_x_q ^ z_eff);
         ALU_XNOR_A, ALU_XNOR_B:
            p_d = inv ? (s1_x_q ^ z_eff) : ~(s1_x_q ^ z_eff);
         ALU_AND:
            p_d = inv ? (s1_x_q | z_eff) : (s1_x_q & z_eff);
         ALU_ANDN:
            p_d = inv ? (s1_x_q | ~z_eff) : (s1_x_q & ~z_eff);
         ALU_NAND:
            p_d = inv ? ~(s1_x_q | z_eff) : ~(s1_x_q & z_eff);
         ALU_NX_OR:
            p_d = inv ? (~s1_x_q & z_eff) : (~s1_x_q | z_eff);
         default: begin
            p_d    = '0;
            cout_d = '0;
         end
      endcase
   end

   assign pd_d = ~|((p_d ^ PATTERN) & ~MASK);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_q    <= '0;
         cout_q <= '0;
         pd_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else if (CLR_P) begin
         p_q    <= '0;
         cout_q <= '0;
         pd_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else if (CE) begin
         if (s1_valid_q) begin
            p_q    <= p_d;
            cout_q <= cout_d;
            pd_q   <= pd_d;
         end
         ov_q <= s1_valid_q;
      end
   end

   assign P              = p_q;
   assign COUT           = cout_q;
   assign PATTERN_DETECT = pd_q;
   assign OUT_VALID      = ov_q;

endmodule

// File: tb/tb_alu_simd_pipe.sv
// Directed-vector bench for alu_simd_pipe with hand-computed expectations.
module tb_alu_simd_pipe;

   localparam int W = 48;

   logic         clk = 1'b0;
   logic         rst, ce, clr_p, in_valid, zsel, cin;
   logic [3:0]   alu_ctrl;
   logic [1:0]   op_mode, use_simd;
   logic [W-1:0] x, y, z, p;
   logic [3:0]   cout;
   logic         pd, ov;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_simd_pipe #(
      .WIDTH(W), .PATTERN(48'h100), .MASK(48'hFF)
   ) dut (
      .CLK(clk), .RST(rst), .CE(ce), .CLR_P(clr_p),
      .IN_VALID(in_valid), .ALU_CTRL(alu_ctrl), .OP_MODE(op_mode),
      .USE_SIMD(use_simd), .ZSEL(zsel), .CIN(cin),
      .X(x), .Y(y), .Z(z), .P(p), .COUT(cout),
      .PATTERN_DETECT(pd), .OUT_VALID(ov)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op(input logic [3:0] c, input logic [1:0] om,
                     input logic [1:0] sm, input logic zs, input logic ci,
                     input logic [W-1:0] xa, input logic [W-1:0] ya,
                     input logic [W-1:0] za);
      in_valid = 1'b1;
      alu_ctrl = c;
      op_mode  = om;
      use_simd = sm;
      zsel     = zs;
      cin      = ci;
      x        = xa;
      y        = ya;
      z        = za;
   endtask

   // issue one operation and advance to its result (2 edges)
   task automatic run1(input logic [3:0] c, input logic [1:0] om,
                       input logic [1:0] sm, input logic ci,
                       input logic [W-1:0] xa, input logic [W-1:0] ya,
                       input logic [W-1:0] za);
      op(c, om, sm, 1'b0, ci, xa, ya, za);
      tick();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic res(input string tag, input logic [W-1:0] ep,
                      input logic [3:0] ec);
      chk({tag, "_p"}, 64'(p), 64'(ep));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
      chk({tag, "_ov"}, 64'(ov), 64'd1);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; clr_p = 1'b0;
      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 48'd5, 48'd3, 48'd10);
      tick(); tick();
      chk("rst_p", 64'(p), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_pd", 64'(pd), 64'd0);
      chk("rst_ov", 64'(ov), 64'd0);
      rst = 1'b0;

      tick();
      chk("fill_ov_edge1", 64'(ov), 64'd0);
      in_valid = 1'b0;
      tick();
      res("fill", 48'd19, 4'b0000);
      chk("fill_pd", 64'(pd), 64'd0);
      tick();
      chk("fill_ov_drop", 64'(ov), 64'd0);
      chk("fill_p_hold", 64'(p), 64'd19);

      run1(4'b0000, 2'b00, 2'b10, 1'b0, 48'h001FFFFFFFFF, 48'd0,
           48'h000001001001);
      res("four_wrap", 48'h001000000000, 4'b0111);
      run1(4'b0000, 2'b00, 2'b00, 1'b0, 48'h001FFFFFFFFF, 48'd0,
           48'h000001001001);
      res("one_wrap", 48'h002001001000, 4'b0000);
      run1(4'b0000, 2'b00, 2'b01, 1'b0, 48'h001FFFFFFFFF, 48'd0,
           48'h000001001001);
      res("two_wrap", 48'h002000001000, 4'b0010);

      run1(4'b0011, 2'b00, 2'b00, 1'b0, 48'd30, 48'd0, 48'd100);
      res("sub", 48'd70, 4'b0000);
      run1(4'b0010, 2'b00, 2'b00, 1'b0, 48'd1, 48'd0, 48'd1);
      res("nsum", 48'hFFFFFFFFFFFD, 4'b0000);
      run1(4'b0001, 2'b00, 2'b00, 1'b1, 48'd0, 48'd0, 48'd0);
      res("nz_carry", 48'd0, 4'b1000);
      run1(4'b1100, 2'b10, 2'b00, 1'b0, 48'hF0, 48'd0, 48'h0F);
      res("or_inv", 48'hFF, 4'b0000);
      run1(4'b1100, 2'b00, 2'b00, 1'b0, 48'hF0, 48'd0, 48'h0F);
      res("and", 48'h0, 4'b0000);
      run1(4'b0100, 2'b00, 2'b00, 1'b0, 48'hFF00, 48'd0, 48'h0FF0);
      res("xor", 48'hF0F0, 4'b0000);
      run1(4'b1101, 2'b00, 2'b00, 1'b0, 48'hFF, 48'd0, 48'h0F);
      res("andn", 48'hF0, 4'b0000);
      run1(4'b1111, 2'b10, 2'b00, 1'b0, 48'h0F0, 48'd0, 48'h0FF);
      res("nx_and_inv", 48'h00F, 4'b0000);
      run1(4'b1000, 2'b00, 2'b00, 1'b1, 48'h123, 48'h4, 48'h5);
      res("zero_code", 48'd0, 4'b0000);

      clr_p = 1'b1;
      tick();
      clr_p = 1'b0;
      chk("clr_p", 64'(p), 64'd0);
      chk("clr_ov", 64'(ov), 64'd0);
      op(4'b0000, 2'b00, 2'b00, 1'b1, 1'b0, 48'd1, 48'd0, 48'd123);
      tick();
      tick(); res("acc1", 48'd1, 4'b0000);
      tick(); res("acc2", 48'd2, 4'b0000);
      tick(); res("acc3", 48'd3, 4'b0000);
      in_valid = 1'b0;
      tick(); res("acc4", 48'd4, 4'b0000);
      tick();
      chk("acc_hold_p", 64'(p), 64'd4);
      chk("acc_hold_ov", 64'(ov), 64'd0);

      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 48'd7, 48'd0, 48'd0);
      tick();
      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 48'd9, 48'd0, 48'd0);
      tick();
      res("pre_stall", 48'd7, 4'b0000);
      ce = 1'b0;
      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 48'd55, 48'd0, 48'd0);
      tick(); tick(); tick();
      chk("stall_p", 64'(p), 64'd7);
      chk("stall_ov", 64'(ov), 64'd1);
      ce = 1'b1;
      in_valid = 1'b0;
      tick();
      res("post_stall", 48'd9, 4'b0000);
      tick();
      chk("post_stall_ov", 64'(ov), 64'd0);
      chk("post_stall_p", 64'(p), 64'd9);

      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b0, 48'd11, 48'd0, 48'd0);
      tick();
      in_valid = 1'b0;
      clr_p = 1'b1;
      tick();
      clr_p = 1'b0;
      chk("clr_win_p", 64'(p), 64'd0);
      chk("clr_win_ov", 64'(ov), 64'd0);

      run1(4'b0000, 2'b00, 2'b00, 1'b0, 48'h2A5, 48'd0, 48'd0);
      res("pat_miss", 48'h2A5, 4'b0000);
      chk("pat_miss_pd", 64'(pd), 64'd0);
      run1(4'b0000, 2'b00, 2'b00, 1'b0, 48'h1A5, 48'd0, 48'd0);
      res("pat_hit", 48'h1A5, 4'b0000);
      chk("pat_hit_pd", 64'(pd), 64'd1);
      tick();
      chk("pat_hold_pd", 64'(pd), 64'd1);

      #2 rst = 1'b1;
      #1;
      chk("async_rst_p", 64'(p), 64'd0);
      chk("async_rst_pd", 64'(pd), 64'd0);
      tick();
      rst = 1'b0;
      op(4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 48'd5, 48'd3, 48'd10);
      tick();
      chk("restart_ov_edge1", 64'(ov), 64'd0);
      in_valid = 1'b0;
      tick();
      res("restart", 48'd19, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
